// File: rtl/arp_pkg.sv
// Shared ARP query types: FSM encoding and IP/MAC widths.
// No logic; latency and backpressure are defined by the users of these types.
package arp_pkg;
  localparam int IP_W  = 32;
  localparam int MAC_W = 48;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_t;
endpackage

// File: rtl/arp_query_arb_if.sv
// Handshake bundle around arp_query_arb; slave = arbiter view, master = environment view.
// Pure wiring: adds no latency and no backpressure of its own.
interface arp_query_arb_if;
  import arp_pkg::*;

  logic             req0_ready_o, req0_valid_i;
  logic [IP_W-1:0]  req0_ip_i;
  logic             req1_ready_o, req1_valid_i;
  logic [IP_W-1:0]  req1_ip_i;
  logic             resp0_ready_i, resp0_valid_o, resp0_err_o;
  logic [MAC_W-1:0] resp0_mac_o;
  logic             resp1_ready_i, resp1_valid_o, resp1_err_o;
  logic [MAC_W-1:0] resp1_mac_o;
  logic             cache_req_ready_i, cache_req_valid_o;
  logic [IP_W-1:0]  cache_ip_o;
  logic             cache_resp_ready_o, cache_resp_valid_i, cache_err_i;
  logic [MAC_W-1:0] cache_mac_i;
  logic             arp_req_ready_i, arp_req_valid_o;
  logic [IP_W-1:0]  arp_req_ip_o;

  modport slave (
    output req0_ready_o, req1_ready_o,
    input  req0_valid_i, req0_ip_i, req1_valid_i, req1_ip_i,
    input  resp0_ready_i, resp1_ready_i,
    output resp0_valid_o, resp0_mac_o, resp0_err_o,
    output resp1_valid_o, resp1_mac_o, resp1_err_o,
    input  cache_req_ready_i,
    output cache_req_valid_o, cache_ip_o,
    output cache_resp_ready_o,
    input  cache_resp_valid_i, cache_mac_i, cache_err_i,
    input  arp_req_ready_i,
    output arp_req_valid_o, arp_req_ip_o
  );

  modport master (
    input  req0_ready_o, req1_ready_o,
    output req0_valid_i, req0_ip_i, req1_valid_i, req1_ip_i,
    output resp0_ready_i, resp1_ready_i,
    input  resp0_valid_o, resp0_mac_o, resp0_err_o,
    input  resp1_valid_o, resp1_mac_o, resp1_err_o,
    output cache_req_ready_i,
    input  cache_req_valid_o, cache_ip_o,
    input  cache_resp_ready_o,
    output cache_resp_valid_i, cache_mac_i, cache_err_i,
    output arp_req_ready_i,
    input  arp_req_valid_o, arp_req_ip_o
  );
endinterface

// File: rtl/arp_query_arb_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant when enabled, registered last-grant.
// Zero latency; a requester not granted simply keeps requesting.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);
  logic last1;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) grant = last1 ? 2'b01 : 2'b10;
      else              grant = req;
    end
  end

  // Reset to "requester 1 last" so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)         last1 <= 1'b1;
    else if (|grant) last1 <= grant[1];
  end
endmodule

// File: rtl/arp_query_arb.sv
// Shares one ARP cache query port between two requesters; one query in flight; miss notifications with per-IP holdoff.
// Accept->cache_req next cycle, response one cycle after cache handshake; requester ready only in IDLE, misses dropped while one is pending.
module arp_query_arb
  import arp_pkg::*;
#(
  parameter int HoldoffCycles = 1000,
  parameter int HoldoffWidth  = 16
) (
  input logic           clk,
  input logic           rst,
  arp_query_arb_if.slave bus
);
  localparam logic [HoldoffWidth-1:0] HOLD_LOAD = HoldoffWidth'(HoldoffCycles);

  state_t             state;
  logic               owner;
  logic [IP_W-1:0]    ip_q, last_miss_ip, arp_ip_q;
  logic [MAC_W-1:0]   mac_q;
  logic               err_q;
  logic               cache_req_vld_q, cache_resp_rdy_q, resp0_vld_q, resp1_vld_q, arp_vld_q;
  logic [HoldoffWidth-1:0] holdoff;
  logic [1:0]         grant;
  logic               resp_taken, miss, raise;

  rr_arb2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   ({bus.req1_valid_i, bus.req0_valid_i}),
    .en    (state == IDLE),
    .grant (grant)
  );

  assign bus.req0_ready_o       = grant[0];
  assign bus.req1_ready_o       = grant[1];
  assign bus.cache_req_valid_o  = cache_req_vld_q;
  assign bus.cache_ip_o         = ip_q;
  assign bus.cache_resp_ready_o = cache_resp_rdy_q;
  assign bus.resp0_valid_o      = resp0_vld_q;
  assign bus.resp1_valid_o      = resp1_vld_q;
  assign bus.resp0_mac_o        = mac_q;
  assign bus.resp1_mac_o        = mac_q;
  assign bus.resp0_err_o        = err_q;
  assign bus.resp1_err_o        = err_q;
  assign bus.arp_req_valid_o    = arp_vld_q;
  assign bus.arp_req_ip_o       = arp_ip_q;

  assign resp_taken = owner ? bus.resp1_ready_i : bus.resp0_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      owner            <= 1'b0;
      ip_q             <= '0;
      mac_q            <= '0;
      err_q            <= 1'b0;
      cache_req_vld_q  <= 1'b0;
      cache_resp_rdy_q <= 1'b0;
      resp0_vld_q      <= 1'b0;
      resp1_vld_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|grant) begin
          ip_q            <= grant[0] ? bus.req0_ip_i : bus.req1_ip_i;
          owner           <= grant[1];
          cache_req_vld_q <= 1'b1;
          state           <= ISSUE;
        end
        ISSUE: if (bus.cache_req_ready_i) begin
          cache_req_vld_q  <= 1'b0;
          cache_resp_rdy_q <= 1'b1;
          state            <= WAIT;
        end
        WAIT: if (bus.cache_resp_valid_i) begin
          mac_q            <= bus.cache_mac_i;
          err_q            <= bus.cache_err_i;
          cache_resp_rdy_q <= 1'b0;
          resp0_vld_q      <= ~owner;
          resp1_vld_q      <= owner;
          state            <= DELIVER;
        end
        DELIVER: if (resp_taken) begin
          resp0_vld_q <= 1'b0;
          resp1_vld_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Notification path runs beside the FSM so a stalled generator never blocks delivery.
  assign miss  = (state == WAIT) && bus.cache_resp_valid_i && bus.cache_err_i;
  assign raise = miss && !((ip_q == last_miss_ip) && (holdoff != '0))
                      && !(arp_vld_q && !bus.arp_req_ready_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      arp_vld_q    <= 1'b0;
      arp_ip_q     <= '0;
      last_miss_ip <= '0;
      holdoff      <= '0;
    end else begin
      if (raise) begin
        arp_vld_q    <= 1'b1;
        arp_ip_q     <= ip_q;
        last_miss_ip <= ip_q;
        holdoff      <= HOLD_LOAD;
      end else begin
        if (arp_vld_q && bus.arp_req_ready_i) arp_vld_q <= 1'b0;
        if (holdoff != '0)                    holdoff   <= holdoff - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_arp_query_arb.sv
// Directed bench for arp_query_arb: arbitration order, latency, miss holdoff/drop, stall and reset.
module tb_arp_query_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  arp_query_arb_if bus();

  arp_query_arb #(.HoldoffCycles(1000), .HoldoffWidth(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int n);
    return (n == 0) ? bus.req0_ready_o : bus.req1_ready_o;
  endfunction

  function automatic logic rvld(input int n);
    return (n == 0) ? bus.resp0_valid_o : bus.resp1_valid_o;
  endfunction

  function automatic logic [47:0] rmac(input int n);
    return (n == 0) ? bus.resp0_mac_o : bus.resp1_mac_o;
  endfunction

  function automatic logic rerr(input int n);
    return (n == 0) ? bus.resp0_err_o : bus.resp1_err_o;
  endfunction

  task automatic set_req(input int n, input logic v, input logic [31:0] ip);
    if (n == 0) begin bus.req0_valid_i = v; bus.req0_ip_i = ip; end
    else        begin bus.req1_valid_i = v; bus.req1_ip_i = ip; end
  endtask

  task automatic set_rresp(input int n, input logic v);
    if (n == 0) bus.resp0_ready_i = v;
    else        bus.resp1_ready_i = v;
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_rdy0"}, bus.req0_ready_o, 0);
    chk({tag, "_rdy1"}, bus.req1_ready_o, 0);
    chk({tag, "_cqv"}, bus.cache_req_valid_o, 0);
    chk({tag, "_cip"}, bus.cache_ip_o, 0);
    chk({tag, "_crr"}, bus.cache_resp_ready_o, 0);
    chk({tag, "_rv0"}, bus.resp0_valid_o, 0);
    chk({tag, "_rv1"}, bus.resp1_valid_o, 0);
    chk({tag, "_mac0"}, bus.resp0_mac_o, 0);
    chk({tag, "_err0"}, bus.resp0_err_o, 0);
    chk({tag, "_arpv"}, bus.arp_req_valid_o, 0);
    chk({tag, "_arpip"}, bus.arp_req_ip_o, 0);
  endtask

  task automatic accept(input int n, input logic [31:0] ip, input logic keep, input string tag);
    set_req(n, 1'b1, ip);
    #1;
    chk({tag, "_grant"}, rdy(n), 1);
    chk({tag, "_nogrant"}, rdy(1 - n), 0);
    chk({tag, "_cqv_pre"}, bus.cache_req_valid_o, 0);
    tick();
    if (!keep) set_req(n, 1'b0, 32'h0);
  endtask

  task automatic issue(input logic [31:0] ip, input string tag);
    chk({tag, "_cqv"}, bus.cache_req_valid_o, 1);
    chk({tag, "_cip"}, bus.cache_ip_o, ip);
    chk({tag, "_rdy_busy"}, bus.req0_ready_o | bus.req1_ready_o, 0);
    bus.cache_req_ready_i = 1'b1;
    tick();
    bus.cache_req_ready_i = 1'b0;
  endtask

  task automatic cresp(input logic [47:0] mac, input logic err, input string tag);
    chk({tag, "_crr"}, bus.cache_resp_ready_o, 1);
    chk({tag, "_cqv_off"}, bus.cache_req_valid_o, 0);
    bus.cache_resp_valid_i = 1'b1;
    bus.cache_mac_i        = mac;
    bus.cache_err_i        = err;
    tick();
    bus.cache_resp_valid_i = 1'b0;
    bus.cache_mac_i        = '0;
    bus.cache_err_i        = 1'b0;
  endtask

  task automatic deliver(input int n, input logic [47:0] mac, input logic err, input string tag);
    chk({tag, "_rv"}, rvld(n), 1);
    chk({tag, "_rv_other"}, rvld(1 - n), 0);
    chk({tag, "_mac"}, rmac(n), mac);
    chk({tag, "_err"}, rerr(n), err);
    chk({tag, "_crr_off"}, bus.cache_resp_ready_o, 0);
    set_rresp(n, 1'b1);
    tick();
    set_rresp(n, 1'b0);
    chk({tag, "_rv_done"}, rvld(n), 0);
  endtask

  task automatic query(input int n, input logic [31:0] ip, input logic [47:0] mac,
                       input logic err, input logic keep, input string tag);
    accept(n, ip, keep, tag);
    issue(ip, tag);
    cresp(mac, err, tag);
    deliver(n, mac, err, tag);
  endtask

  initial begin
    bus.req0_valid_i = 0; bus.req0_ip_i = 0; bus.req1_valid_i = 0; bus.req1_ip_i = 0;
    bus.resp0_ready_i = 0; bus.resp1_ready_i = 0;
    bus.cache_req_ready_i = 0; bus.cache_resp_valid_i = 0; bus.cache_mac_i = 0; bus.cache_err_i = 0;
    bus.arp_req_ready_i = 0;

    tick(); tick();
    outputs_zero("reset");
    rst = 1'b0;
    #1;

    // Simultaneous requesters from reset: grants alternate starting with 0.
    set_req(0, 1'b1, 32'h0B000000);
    set_req(1, 1'b1, 32'h0B000001);
    for (int k = 0; k < 6; k++) begin
      query(k % 2, 32'h0B000000 + k, 48'hAA0000000000 + 48'(k), 1'b0, k < 4, $sformatf("rr%0d", k));
      if (k < 4) set_req(k % 2, 1'b1, 32'h0B000000 + 32'(k + 2));
    end
    chk("rr_noarp", bus.arp_req_valid_o, 0);

    rst = 1'b1; tick(); rst = 1'b0;
    query(0, 32'h0A000001, 48'h001122334455, 1'b0, 1'b0, "hit");
    chk("hit_noarp", bus.arp_req_valid_o, 0);

    query(0, 32'h0A000002, 48'h0, 1'b1, 1'b0, "miss1");
    chk("miss1_arpv", bus.arp_req_valid_o, 1);
    chk("miss1_arpip", bus.arp_req_ip_o, 32'h0A000002);
    bus.arp_req_ready_i = 1'b1; tick(); bus.arp_req_ready_i = 1'b0;
    chk("miss1_arp_clr", bus.arp_req_valid_o, 0);

    query(1, 32'h0A000002, 48'h0, 1'b1, 1'b0, "miss2");
    chk("miss2_suppressed", bus.arp_req_valid_o, 0);

    repeat (1100) tick();
    query(0, 32'h0A000002, 48'h0, 1'b1, 1'b0, "miss3");
    chk("miss3_arpv", bus.arp_req_valid_o, 1);
    chk("miss3_arpip", bus.arp_req_ip_o, 32'h0A000002);
    bus.arp_req_ready_i = 1'b1; tick(); bus.arp_req_ready_i = 1'b0;

    query(0, 32'h0A000003, 48'h0, 1'b1, 1'b0, "drop_a");
    chk("drop_a_arpv", bus.arp_req_valid_o, 1);
    query(1, 32'h0A000004, 48'h0, 1'b1, 1'b0, "drop_b");
    chk("drop_b_arpv", bus.arp_req_valid_o, 1);
    chk("drop_b_arpip", bus.arp_req_ip_o, 32'h0A000003);
    bus.arp_req_ready_i = 1'b1; tick(); bus.arp_req_ready_i = 1'b0;
    chk("drop_clr", bus.arp_req_valid_o, 0);

    // Owner stalls DELIVER while both requesters knock.
    accept(0, 32'h0A000005, 1'b0, "stall");
    issue(32'h0A000005, "stall");
    cresp(48'hCAFEF00D1234, 1'b0, "stall");
    set_req(0, 1'b1, 32'h0A000006);
    set_req(1, 1'b1, 32'h0A000007);
    for (int c = 0; c < 10; c++) begin
      chk("stall_rv0", bus.resp0_valid_o, 1);
      chk("stall_mac0", bus.resp0_mac_o, 48'hCAFEF00D1234);
      chk("stall_err0", bus.resp0_err_o, 0);
      chk("stall_rdy", {bus.req0_ready_o, bus.req1_ready_o}, 0);
      chk("stall_cqv", bus.cache_req_valid_o, 0);
      tick();
    end
    set_req(0, 1'b0, 32'h0);
    set_req(1, 1'b0, 32'h0);
    deliver(0, 48'hCAFEF00D1234, 1'b0, "stall_rel");

    // Reset while waiting on the cache.
    accept(1, 32'h0A000008, 1'b0, "rstw");
    issue(32'h0A000008, "rstw");
    chk("rstw_in_wait", bus.cache_resp_ready_o, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    outputs_zero("rstw");
    query(1, 32'h0A000009, 48'h665544332211, 1'b0, 1'b0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
